// File: rtl/modexp_arb_pkg.sv
// Shared types and helpers for the modular-exponentiation engine arbiter.
// Holds the sequencer state encoding, the default operand width and the index-width helper.
package modexp_arb_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Width of an index into n requesters; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/modexp_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; returns the first set req bit
// searching from rr_ptr upward with wrap. rr_ptr must be below N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  int            pos;
  logic [IW-1:0] cand;

  // NOTE: every output and temporary gets a default before any conditional
  // assignment, so this block can never infer a latch.
  always_comb begin
    valid = |req;
    idx   = '0;
    pos   = 0;
    cand  = '0;
    // Walk offsets from farthest to nearest so the closest set bit wins last.
    for (int off = N - 1; off >= 0; off--) begin
      pos = int'(rr_ptr) + off;
      if (pos >= N) pos = pos - N;
      cand = IW'(pos);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/modexp_arbiter.sv
// Round-robin sequencer sharing one modular-exponentiation engine among NUM_REQ requesters.
// Optional watchdog on the engine wait is enabled with `define MODEXP_ARB_TIMEOUT_EN.
module modexp_arbiter
  import modexp_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] base_in,
  input  logic [NUM_REQ*WIDTH-1:0] exp_in,
  input  logic [NUM_REQ*WIDTH-1:0] mod_in,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH-1:0]         result,
  output logic                     err,
  output logic                     md_start,
  output logic [WIDTH-1:0]         eng_base,
  output logic [WIDTH-1:0]         eng_exp,
  output logic [WIDTH-1:0]         eng_mod,
  input  logic [WIDTH-1:0]         eng_r,
  input  logic                     md_end
);

  localparam int IW = idx_width(NUM_REQ);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("modexp_arbiter: NUM_REQ must be at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("modexp_arbiter: TIMEOUT_CYC must be at least 1");
  end

  arb_state_t    state, state_nx;
  logic [IW-1:0] rr_ptr, grant_idx, pick_idx;
  logic          pick_valid;
  logic [WIDTH-1:0] res_reg;
  logic          timed_out;

  logic [WIDTH-1:0] base_arr [NUM_REQ];
  logic [WIDTH-1:0] exp_arr  [NUM_REQ];
  logic [WIDTH-1:0] mod_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign base_arr[g] = base_in[g*WIDTH +: WIDTH];
    assign exp_arr[g]  = exp_in[g*WIDTH +: WIDTH];
    assign mod_arr[g]  = mod_in[g*WIDTH +: WIDTH];
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

`ifdef MODEXP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] wait_cnt;
  logic          err_reg;

  // Fires on the last permitted WAIT cycle, giving exactly TIMEOUT_CYC WAIT cycles.
  assign timed_out = (wait_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wait_cnt <= '0;
      err_reg  <= 1'b0;
    end else begin
      case (state)
        ISSUE: begin
          wait_cnt <= '0;
          err_reg  <= 1'b0;
        end
        WAIT: begin
          if (md_end)         err_reg  <= 1'b0;
          else if (timed_out) err_reg  <= 1'b1;
          else                wait_cnt <= wait_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign err = (state == RESP) && err_reg;
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples its inputs as they stood before the clock edge.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_valid) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (md_end || timed_out) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: the operand and result registers are few and observable on ports,
  // so they are reset along with control; nothing here is a memory array.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr    <= '0;
      grant_idx <= '0;
      eng_base  <= '0;
      eng_exp   <= '0;
      eng_mod   <= '0;
      res_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_idx <= pick_idx;
            eng_base  <= base_arr[pick_idx];
            eng_exp   <= exp_arr[pick_idx];
            eng_mod   <= mod_arr[pick_idx];
          end
        end
        WAIT: begin
          if (md_end)         res_reg <= eng_r;
          else if (timed_out) res_reg <= '0;
        end
        RESP: begin
          rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack      = '0;
    done     = '0;
    md_start = 1'b0;
    result   = '0;
    case (state)
      ISSUE: begin
        ack[grant_idx] = 1'b1;
        md_start       = 1'b1;
      end
      RESP: begin
        done[grant_idx] = 1'b1;
        result          = res_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_modexp_arbiter.sv
// Self-checking bench for modexp_arbiter: randomized jobs against a behavioural engine
// and round-robin model; watchdog scenario runs when MODEXP_ARB_TIMEOUT_EN is defined.
module tb_modexp_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   req;
  logic [N*W-1:0] base_in, exp_in, mod_in;
  logic [N-1:0]   ack, done;
  logic [W-1:0]   result, eng_base, eng_exp, eng_mod, eng_r;
  logic           err, md_start, md_end;

  always #5 clk = ~clk;

  modexp_arbiter #(
    .NUM_REQ     (N),
    .WIDTH       (W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .base_in  (base_in),
    .exp_in   (exp_in),
    .mod_in   (mod_in),
    .ack      (ack),
    .done     (done),
    .result   (result),
    .err      (err),
    .md_start (md_start),
    .eng_base (eng_base),
    .eng_exp  (eng_exp),
    .eng_mod  (eng_mod),
    .eng_r    (eng_r),
    .md_end   (md_end)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] op_b [N];
  logic [W-1:0] op_e [N];
  logic [W-1:0] op_m [N];
  int           m_ptr;
  int           grant_log [$];
  int           start_cnt [N];
  logic [W-1:0] last_result;
  int           last_done_idx;

  // Engine behaviour: base^exp mod m by square-and-multiply; modulus 0 yields 0.
  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                               input logic [W-1:0] m);
    longint unsigned r, x, mm;
    if (m == '0) return '0;
    mm = 64'(m);
    r  = 64'd1 % mm;
    x  = 64'(b) % mm;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return W'(r);
  endfunction

  // Round-robin rule: first requesting index at ptr, ptr+1, ... modulo N.
  function automatic int ref_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] b, input logic [W-1:0] e,
                        input logic [W-1:0] m);
    op_b[i] = b;
    op_e[i] = e;
    op_m[i] = m;
    base_in[i*W +: W] = b;
    exp_in[i*W +: W]  = e;
    mod_in[i*W +: W]  = m;
  endtask

  task automatic rand_op(input int i);
    logic [W-1:0] e, m;
    e = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
    m = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
    set_op(i, W'($urandom), e, m);
  endtask

  // Runs the engine model and checks every cycle until n_jobs results have returned.
  task automatic serve(input int n_jobs, input bit drop_each, input bit stray_issue,
                       input int budget, output int first_ack);
    int jobs, cyc, eng_cnt, cur, md_cyc, act, exp_g;
    logic [W-1:0] eng_val, exp_r;
    jobs = 0; cyc = 0; eng_cnt = 0; cur = -1; md_cyc = -1; first_ack = -1; eng_val = '0;
    while (jobs < n_jobs && cyc < budget) begin
      @(negedge clk);
      cyc++;
      md_end = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          md_end = 1'b1;
          eng_r  = eng_val;
          md_cyc = cyc;
        end
      end
      n_tests++;
      if (err !== 1'b0) begin
        n_fail++; $display("FAIL err_idle: got %b expected 0 (cycle %0d)", err, cyc);
      end
      if (done === '0) begin
        n_tests++;
        if (result !== '0) begin
          n_fail++; $display("FAIL result_idle: got %h expected 0", result);
        end
      end
      if (ack !== '0) begin
        act = -1;
        for (int i = N - 1; i >= 0; i--) if (ack[i]) act = i;
        exp_g = ref_pick(req, m_ptr);
        n_tests++;
        if (exp_g < 0 || ack !== (N'(1) << exp_g)) begin
          n_fail++; $display("FAIL grant: got ack %b expected requester %0d", ack, exp_g);
        end
        grant_log.push_back(act);
        if (first_ack < 0) first_ack = cyc;
        n_tests++;
        if (md_start !== 1'b1) begin
          n_fail++; $display("FAIL md_start_with_ack: got %b expected 1", md_start);
        end
        n_tests++;
        if ({eng_base, eng_exp, eng_mod} !== {op_b[act], op_e[act], op_m[act]}) begin
          n_fail++;
          $display("FAIL operands: got %h/%h/%h expected %h/%h/%h", eng_base, eng_exp,
                   eng_mod, op_b[act], op_e[act], op_m[act]);
        end
        cur = act;
        start_cnt[act]++;
        eng_val = ref_modexp(eng_base, eng_exp, eng_mod);
        eng_cnt = $urandom_range(1, 5);
        md_cyc  = -1;
        if (stray_issue) begin
          md_end = 1'b1;
          eng_r  = W'($urandom);
        end
      end else begin
        n_tests++;
        if (md_start !== 1'b0) begin
          n_fail++; $display("FAIL md_start_without_ack: got %b expected 0", md_start);
        end
      end
      if (done !== '0) begin
        n_tests++;
        if (cur < 0 || done !== (N'(1) << cur)) begin
          n_fail++; $display("FAIL done_onehot: got %b expected requester %0d", done, cur);
        end else begin
          n_tests++;
          if (md_cyc < 0 || cyc - md_cyc > 2) begin
            n_fail++; $display("FAIL done_latency: got md_end cycle %0d, done cycle %0d", md_cyc, cyc);
          end
          exp_r = ref_modexp(op_b[cur], op_e[cur], op_m[cur]);
          n_tests++;
          if (result !== exp_r) begin
            n_fail++; $display("FAIL result: got %h expected %h (req %0d)", result, exp_r, cur);
          end
          last_result   = result;
          last_done_idx = cur;
          m_ptr = (cur + 1) % N;
          jobs++;
          if (drop_each || jobs == n_jobs) req[cur] = 1'b0;
        end
        cur = -1;
      end
    end
    n_tests++;
    if (jobs != n_jobs) begin
      n_fail++; $display("FAIL serve_budget: got %0d jobs expected %0d", jobs, n_jobs);
    end
  endtask

  task automatic check_quiet(input string name, input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      n_tests++;
      if (done !== '0 || ack !== '0 || md_start !== 1'b0) begin
        n_fail++; $display("FAIL %s: got done %b ack %b md_start %b expected all 0", name, done, ack, md_start);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; req = '0; md_end = 1'b0; eng_r = '0;
    base_in = '0; exp_in = '0; mod_in = '0;
    for (int i = 0; i < N; i++) start_cnt[i] = 0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({ack, done, md_start, err} !== '0) begin
      n_fail++; $display("FAIL reset_ctrl: got ack %b done %b md_start %b err %b expected 0", ack, done, md_start, err);
    end
    n_tests++;
    if (result !== '0) begin
      n_fail++; $display("FAIL reset_result: got %h expected 0", result);
    end
    n_tests++;
    if ({eng_base, eng_exp, eng_mod} !== '0) begin
      n_fail++; $display("FAIL reset_eng: got %h/%h/%h expected 0", eng_base, eng_exp, eng_mod);
    end
    rstn  = 1'b1;
    m_ptr = 0;
    check_quiet("reset_idle", 2);
  endtask

  task automatic test_single();
    int fa;
    set_op(0, 32'd3, 32'd1, 32'd7);
    req = 4'b0001;
    serve(1, 1'b1, 1'b0, 50, fa);
    n_tests++;
    if (fa != 1) begin
      n_fail++; $display("FAIL single_ack_latency: got %0d cycles expected 1", fa);
    end
    n_tests++;
    if (last_result !== 32'd3 || last_done_idx != 0) begin
      n_fail++; $display("FAIL single_result: got %0d from %0d expected 3 from 0", last_result, last_done_idx);
    end
    n_tests++;
    if (start_cnt[0] != 1) begin
      n_fail++; $display("FAIL single_starts: got %0d expected 1", start_cnt[0]);
    end
  endtask

  task automatic test_compute();
    int fa;
    set_op(2, 32'd5, 32'd3, 32'd13);
    req = 4'b0100;
    serve(1, 1'b1, 1'b0, 50, fa);
    n_tests++;
    if (last_result !== 32'd8 || last_done_idx != 2) begin
      n_fail++; $display("FAIL compute_result: got %0d from %0d expected 8 from 2", last_result, last_done_idx);
    end
  endtask

  task automatic check_order(input string name, input int exp_o [$]);
    n_tests++;
    if (grant_log.size() != exp_o.size()) begin
      n_fail++; $display("FAIL %s_len: got %0d grants expected %0d", name, grant_log.size(), exp_o.size());
    end else begin
      for (int i = 0; i < exp_o.size(); i++) begin
        n_tests++;
        if (grant_log[i] != exp_o[i]) begin
          n_fail++; $display("FAIL %s[%0d]: got %0d expected %0d", name, i, grant_log[i], exp_o[i]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int fa;
    rstn = 1'b0;
    @(negedge clk);
    rstn  = 1'b1;
    m_ptr = 0;
    for (int i = 0; i < N; i++) rand_op(i);
    grant_log.delete();
    req = 4'b1111;
    serve(4, 1'b1, 1'b0, 200, fa);
    check_order("rr_all", '{0, 1, 2, 3});
    grant_log.delete();
    req = 4'b0110;
    serve(2, 1'b1, 1'b0, 100, fa);
    check_order("rr_0110", '{1, 2});
    grant_log.delete();
    req = 4'b0011;
    serve(2, 1'b1, 1'b0, 100, fa);
    check_order("rr_0011", '{0, 1});
  endtask

  task automatic test_random();
    int fa, cnt;
    logic [N-1:0] mask;
    for (int round = 0; round < 6; round++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      cnt = 0;
      for (int i = 0; i < N; i++) begin
        rand_op(i);
        if (mask[i]) cnt++;
      end
      req = mask;
      serve(cnt, 1'b1, 1'b0, 300, fa);
    end
  endtask

  task automatic test_stray();
    int fa;
    @(negedge clk);
    md_end = 1'b1;
    eng_r  = W'($urandom);
    @(negedge clk);
    md_end = 1'b0;
    check_quiet("stray_idle", 4);
    for (int i = 0; i < N; i++) start_cnt[i] = 0;
    rand_op(1);
    req = 4'b0010;
    serve(2, 1'b0, 1'b1, 100, fa);
    n_tests++;
    if (start_cnt[1] != 2) begin
      n_fail++; $display("FAIL stray_jobs: got %0d jobs for req 1 expected 2", start_cnt[1]);
    end
    check_quiet("stray_after", 5);
  endtask

  task automatic test_reset_wait();
    int fa;
    bit got;
    rand_op(3);
    req = 4'b1000;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (ack !== '0) got = 1'b1;
    end
    n_tests++;
    if (!got || ack !== 4'b1000) begin
      n_fail++; $display("FAIL rst_wait_ack: got %b expected 1000", ack);
    end
    req = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ack, done, md_start, err} !== '0 || result !== '0) begin
      n_fail++; $display("FAIL rst_wait_outputs: got ack %b done %b md_start %b err %b result %h expected 0", ack, done, md_start, err, result);
    end
    n_tests++;
    if ({eng_base, eng_exp, eng_mod} !== '0) begin
      n_fail++; $display("FAIL rst_wait_eng: got %h/%h/%h expected 0", eng_base, eng_exp, eng_mod);
    end
    rstn  = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    md_end = 1'b1;
    eng_r  = W'($urandom);
    @(negedge clk);
    md_end = 1'b0;
    check_quiet("rst_wait_stray", 4);
    rand_op(0); rand_op(2); rand_op(3);
    grant_log.delete();
    req = 4'b1101;
    serve(3, 1'b1, 1'b0, 200, fa);
    check_order("rst_wait_order", '{0, 2, 3});
  endtask

`ifdef MODEXP_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    bit got;
    rand_op(2);
    req = 4'b0100;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (ack !== '0) got = 1'b1;
    end
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL timeout_ack: got no ack expected one");
    end
    req = '0;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 60) begin
      @(negedge clk);
      cnt++;
      if (done !== '0) got = 1'b1;
    end
    n_tests++;
    if (cnt != TO + 1) begin
      n_fail++; $display("FAIL timeout_len: got done %0d cycles after ack expected %0d", cnt, TO + 1);
    end
    n_tests++;
    if (done !== 4'b0100 || err !== 1'b1 || result !== '0) begin
      n_fail++; $display("FAIL timeout_resp: got done %b err %b result %h expected 0100/1/0", done, err, result);
    end
    m_ptr = 3;
    check_quiet("timeout_after", 3);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_compute();
    test_round_robin();
    test_random();
    test_stray();
    test_reset_wait();
`ifdef MODEXP_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
